// File: rtl/bounce_gen.sv
// bounce_gen
//   Switch-bounce emulator. A clean, synchronous commanded level `in` is
//   turned into a chattering pin `out`. The chatter lasts a fixed window of
//   BOUNCE_TIME cycles and is driven by a seedable 16-bit Galois LFSR, so
//   the bounce pattern is identical on every run. At the end of the window
//   the pin settles to the commanded level.
//
// Parameters
//   BOUNCE_TIME : bounce window length in clock cycles (2..65535)
//   MAX_GLITCH  : longest single bounce segment in cycles (power of 2, 1..16)
//   SEED        : LFSR reset value (nonzero)
//
// Ports
//   clk      in   system clock, all logic on the rising edge
//   rst      in   synchronous, active-high reset
//   in       in   commanded clean level, already synchronous to clk
//   out      out  bouncy emulated pin
//   busy     out  high while a bounce window is in progress
//   edge_cnt out  transitions of `out` in the current or last window,
//                 saturating at 255
module bounce_gen #(
  parameter int unsigned BOUNCE_TIME = 16,
  parameter int unsigned MAX_GLITCH  = 4,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in,
  output logic       out,
  output logic       busy,
  output logic [7:0] edge_cnt
);

  typedef enum logic {
    IDLE,
    BOUNCE
  } state_t;

  localparam logic [15:0] LFSR_MASK   = 16'hB400;
  localparam logic [15:0] WINDOW_LAST = 16'(BOUNCE_TIME - 1);
  localparam logic [4:0]  GLITCH_MASK = 5'(MAX_GLITCH - 1);

  state_t      state_q, state_d;
  logic        target_q, target_d;
  logic [15:0] cnt_q, cnt_d;
  logic [4:0]  seg_q, seg_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic        out_q, out_d;
  logic        busy_q, busy_d;
  logic [7:0]  edge_q, edge_d;

  logic [15:0] lfsr_next;
  logic [4:0]  seg_len;
  logic [7:0]  edge_inc;

  // Galois step: shift right and fold the mask back in whenever a 1 falls
  // out of bit 0. The segment length is taken from the pre-advance value so
  // the pattern lines up with the register contents of the same cycle.
  always_comb begin
    lfsr_next = lfsr_q >> 1;
    if (lfsr_q[0]) begin
      lfsr_next = (lfsr_q >> 1) ^ LFSR_MASK;
    end
    seg_len  = ({1'b0, lfsr_q[3:0]} & GLITCH_MASK) + 5'd1;
    edge_inc = (edge_q == 8'hFF) ? edge_q : edge_q + 8'd1;
  end

  // Next-state logic. In IDLE a mismatch between `in` and the pin opens a
  // window with an immediate first toggle. In BOUNCE `in` is ignored; the
  // window counter runs down and the segment counter decides when the pin
  // flips. On the last window cycle the pin is forced to the latched
  // target, which only counts as an edge if it really changes the pin.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    seg_d    = seg_q;
    lfsr_d   = lfsr_next;
    out_d    = out_q;
    edge_d   = edge_q;

    case (state_q)
      IDLE: begin
        if (in != out_q) begin
          state_d  = BOUNCE;
          target_d = in;
          out_d    = ~out_q;
          cnt_d    = WINDOW_LAST;
          seg_d    = seg_len;
          edge_d   = 8'd1;
        end
      end
      BOUNCE: begin
        if (cnt_q == 16'd0) begin
          state_d = IDLE;
          out_d   = target_q;
          if (out_q != target_q) begin
            edge_d = edge_inc;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
          if (seg_q == 5'd1) begin
            out_d  = ~out_q;
            edge_d = edge_inc;
            seg_d  = seg_len;
          end else begin
            seg_d = seg_q - 5'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == BOUNCE);
  end

  // All state, including the registered outputs, updates here. Reset wins
  // over everything, so a reset in the middle of a window aborts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      target_q <= 1'b0;
      cnt_q    <= 16'd0;
      seg_q    <= 5'd0;
      lfsr_q   <= SEED;
      out_q    <= 1'b0;
      busy_q   <= 1'b0;
      edge_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      seg_q    <= seg_d;
      lfsr_q   <= lfsr_d;
      out_q    <= out_d;
      busy_q   <= busy_d;
      edge_q   <= edge_d;
    end
  end

  assign out      = out_q;
  assign busy     = busy_q;
  assign edge_cnt = edge_q;

endmodule

// File: tb/tb_bounce_gen.sv
// Testbench for bounce_gen.
//   u_a : BOUNCE_TIME=16, MAX_GLITCH=4, checked cycle-for-cycle against a
//         behavioural LFSR model and with hand-written window sequences.
//   u_b : BOUNCE_TIME=8, MAX_GLITCH=1, fully deterministic, checked against
//         a table of hand-computed vectors.
module tb_bounce_gen;

  localparam int A_BT = 16;
  localparam int A_MG = 4;

  logic       clk = 1'b0;
  logic       rst_a = 1'b1;
  logic       in_a = 1'b0;
  logic       out_a, busy_a;
  logic [7:0] edge_a;
  logic       rst_b = 1'b1;
  logic       in_b = 1'b0;
  logic       out_b, busy_b;
  logic [7:0] edge_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bounce_gen #(.BOUNCE_TIME(A_BT), .MAX_GLITCH(A_MG), .SEED(16'hACE1)) u_a (
    .clk(clk), .rst(rst_a), .in(in_a),
    .out(out_a), .busy(busy_a), .edge_cnt(edge_a)
  );

  bounce_gen #(.BOUNCE_TIME(8), .MAX_GLITCH(1), .SEED(16'hACE1)) u_b (
    .clk(clk), .rst(rst_b), .in(in_b),
    .out(out_b), .busy(busy_b), .edge_cnt(edge_b)
  );

  // Behavioural model of u_a, written straight from the operating rules.
  typedef struct {
    bit          in_window;
    bit          tgt;
    int          cnt;
    int          seg;
    logic [15:0] lfsr;
    bit          pin;
    int          edges;
  } model_t;

  model_t m = '{0, 0, 0, 0, 16'hACE1, 0, 0};

  function automatic model_t model_step(input model_t s, input logic r, input logic i);
    model_t n;
    int     len;
    n = s;
    if (r) begin
      n = '{0, 0, 0, 0, 16'hACE1, 0, 0};
      return n;
    end
    len    = int'(s.lfsr % A_MG) + 1;
    n.lfsr = s.lfsr[0] ? ((s.lfsr >> 1) ^ 16'hB400) : (s.lfsr >> 1);
    if (!s.in_window) begin
      if (i != s.pin) begin
        n.in_window = 1;
        n.tgt       = i;
        n.pin       = !s.pin;
        n.cnt       = A_BT - 1;
        n.seg       = len;
        n.edges     = 1;
      end
    end else if (s.cnt == 0) begin
      n.in_window = 0;
      if (s.pin != s.tgt) begin
        n.pin   = s.tgt;
        n.edges = (s.edges >= 255) ? 255 : s.edges + 1;
      end
    end else begin
      n.cnt = s.cnt - 1;
      if (s.seg == 1) begin
        n.pin   = !s.pin;
        n.edges = (s.edges >= 255) ? 255 : s.edges + 1;
        n.seg   = len;
      end else begin
        n.seg = s.seg - 1;
      end
    end
    return n;
  endfunction

  // Inputs change on the falling edge, so the model sees the same values
  // the DUT samples.
  always @(posedge clk) begin
    m <= model_step(m, rst_a, in_a);
  end

  typedef struct {
    logic rst;
    logic in;
    logic out;
    logic busy;
    int   edges;
  } vec_t;

  vec_t vecs[31];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // One table vector against u_b.
  task automatic applyStimulus(input int idx);
    @(negedge clk);
    rst_b = vecs[idx].rst;
    in_b  = vecs[idx].in;
    @(posedge clk);
    #1;
    checkOutput($sformatf("vec%0d_out", idx), int'(out_b), int'(vecs[idx].out));
    checkOutput($sformatf("vec%0d_busy", idx), int'(busy_b), int'(vecs[idx].busy));
    checkOutput($sformatf("vec%0d_edge", idx), int'(edge_b), vecs[idx].edges);
  endtask

  // One cycle of u_a with a lockstep comparison against the model.
  task automatic step_a(input logic r, input logic i);
    @(negedge clk);
    rst_a = r;
    in_a  = i;
    @(posedge clk);
    #1;
    checkOutput("model_out", int'(out_a), int'(m.pin));
    checkOutput("model_busy", int'(busy_a), int'(m.in_window));
    checkOutput("model_edge", int'(edge_a), m.edges);
  endtask

  // Opens a window on u_a by driving `lvl` and runs it to completion,
  // optionally wiggling `in` in the middle. Returns the busy cycle count.
  task automatic run_window(input logic lvl, input bit wiggle, output int nbusy);
    logic iv;
    nbusy = 0;
    for (int k = 0; k < 40; k++) begin
      iv = lvl;
      if (wiggle && k >= 1 && k <= 14 && (k % 2 == 1)) iv = ~lvl;
      step_a(1'b0, iv);
      if (busy_a) nbusy++;
      else if (k > 0) break;
    end
  endtask

  int nb;

  initial begin
    vecs[0]  = '{1, 0, 0, 0, 0};
    vecs[1]  = '{1, 0, 0, 0, 0};
    vecs[2]  = '{1, 0, 0, 0, 0};
    vecs[3]  = '{0, 0, 0, 0, 0};
    vecs[4]  = '{0, 1, 1, 1, 1};
    vecs[5]  = '{0, 1, 0, 1, 2};
    vecs[6]  = '{0, 1, 1, 1, 3};
    vecs[7]  = '{0, 1, 0, 1, 4};
    vecs[8]  = '{0, 1, 1, 1, 5};
    vecs[9]  = '{0, 1, 0, 1, 6};
    vecs[10] = '{0, 1, 1, 1, 7};
    vecs[11] = '{0, 1, 0, 1, 8};
    vecs[12] = '{0, 1, 1, 0, 9};
    vecs[13] = '{0, 1, 1, 0, 9};
    vecs[14] = '{0, 0, 0, 1, 1};
    vecs[15] = '{0, 1, 1, 1, 2};
    vecs[16] = '{0, 0, 0, 1, 3};
    vecs[17] = '{0, 1, 1, 1, 4};
    vecs[18] = '{0, 0, 0, 1, 5};
    vecs[19] = '{0, 1, 1, 1, 6};
    vecs[20] = '{0, 0, 0, 1, 7};
    vecs[21] = '{0, 1, 1, 1, 8};
    vecs[22] = '{0, 1, 0, 0, 9};
    vecs[23] = '{0, 1, 1, 1, 1};
    vecs[24] = '{0, 1, 0, 1, 2};
    vecs[25] = '{1, 1, 0, 0, 0};
    vecs[26] = '{0, 1, 1, 1, 1};
    vecs[27] = '{0, 1, 0, 1, 2};
    vecs[28] = '{1, 0, 0, 0, 0};
    vecs[29] = '{0, 0, 0, 0, 0};
    vecs[30] = '{0, 0, 0, 0, 0};

    $display("[TB] worst-chatter table on u_b");
    for (int v = 0; v < 31; v++) begin
      applyStimulus(v);
    end

    $display("[TB] reset and idle on u_a");
    for (int k = 0; k < 3; k++) begin
      step_a(1'b1, 1'b0);
    end
    for (int k = 0; k < 6; k++) begin
      step_a(1'b0, 1'b0);
      checkOutput("idle_out", int'(out_a), 0);
      checkOutput("idle_busy", int'(busy_a), 0);
      checkOutput("idle_edge", int'(edge_a), 0);
    end

    $display("[TB] single press on u_a");
    run_window(1'b1, 1'b0, nb);
    checkOutput("press_busy_len", nb, 16);
    checkOutput("press_out_final", int'(out_a), 1);
    checkOutput("press_busy_final", int'(busy_a), 0);
    checkOutput("press_edge_odd", int'(edge_a[0]), 1);
    checkOutput("press_edge_le16", int'(edge_a <= 8'd16), 1);

    $display("[TB] ignored input on u_a");
    run_window(1'b0, 1'b0, nb);
    checkOutput("release_out_final", int'(out_a), 0);
    run_window(1'b1, 1'b1, nb);
    checkOutput("wiggle_busy_len", nb, 16);
    checkOutput("wiggle_out_final", int'(out_a), 1);
    step_a(1'b0, 1'b1);
    checkOutput("no_second_window", int'(busy_a), 0);
    step_a(1'b0, 1'b0);
    checkOutput("new_window_busy", int'(busy_a), 1);
    checkOutput("new_window_edge", int'(edge_a), 1);
    run_window(1'b0, 1'b0, nb);
    checkOutput("new_window_len", nb, 15);
    checkOutput("new_window_out", int'(out_a), 0);

    $display("[TB] mid-window reset on u_a");
    for (int k = 0; k < 5; k++) begin
      step_a(1'b0, 1'b1);
    end
    checkOutput("pre_reset_busy", int'(busy_a), 1);
    step_a(1'b1, 1'b1);
    checkOutput("abort_out", int'(out_a), 0);
    checkOutput("abort_busy", int'(busy_a), 0);
    checkOutput("abort_edge", int'(edge_a), 0);
    step_a(1'b0, 1'b1);
    checkOutput("restart_out", int'(out_a), 1);
    checkOutput("restart_busy", int'(busy_a), 1);
    checkOutput("restart_edge", int'(edge_a), 1);
    run_window(1'b1, 1'b0, nb);
    checkOutput("restart_len", nb, 15);
    checkOutput("restart_out_final", int'(out_a), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
